// File: rtl/clk_en_gen_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// The rate helpers are plain constant functions, so they work in parameters and benches alike.
package clk_en_gen_pkg;

  // Per-channel status bundle handed from each NCO up to the top level.
  typedef struct packed {
    logic ce;
    logic pending;
  } nco_status_t;

  // Width of a counter that must reach lock_cycles (lock_cycles >= 1).
  function automatic int unsigned lock_cw(int unsigned lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

  // Rounded increment giving f_out_hz strobes from an f_ref_hz clock with an acc_w-bit phase.
  function automatic longint unsigned inc_for(longint unsigned f_ref_hz,
                                              longint unsigned f_out_hz,
                                              int unsigned     acc_w);
    return ((f_out_hz << acc_w) + (f_ref_hz >> 1)) / f_ref_hz;
  endfunction

  localparam longint unsigned RefclkHz = 64'd108_000_000;

  localparam logic [31:0] VgaInc108M    = 32'(inc_for(RefclkHz, 64'd25_175_000, 32));
  localparam logic [31:0] Tick60Inc108M = 32'(inc_for(RefclkHz, 64'd60, 32));

endpackage

// File: rtl/clk_en_gen_nco.sv
// One NCO channel: phase accumulator, shadowed increment and registered strobe output.
// Increment changes are deferred to a wrap (or idle/sync) so every period is whole.
module clk_en_gen_nco
  import clk_en_gen_pkg::*;
#(
  parameter int unsigned       ACC_W    = 32,
  parameter logic [ACC_W-1:0]  INIT_INC = {2'b01, {(ACC_W-2){1'b0}}}
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              sync_i,
  input  logic              we_i,
  input  logic [ACC_W-1:0]  inc_i,
  output nco_status_t       status_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] active_q, active_d;
  logic [ACC_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             carry_q, carry_d;
  logic             ce_q, ce_d;

  logic [ACC_W:0]   sum;
  logic             wrap;
  logic             apply;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, active_q};
    wrap  = en_i & ~sync_i & sum[ACC_W];
    apply = wrap | ~en_i | sync_i;

    acc_d   = acc_q;
    carry_d = 1'b0;
    ce_d    = 1'b0;
    if (sync_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d   = sum[ACC_W-1:0];
      carry_d = sum[ACC_W];
      ce_d    = carry_q;
    end

    // The wrapping add above still uses active_q; the new rate starts from the next step.
    active_d  = apply ? shadow_q : active_q;
    pending_d = apply ? 1'b0 : pending_q;
    shadow_d  = shadow_q;
    if (we_i) begin
      shadow_d  = inc_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      active_q  <= INIT_INC;
      shadow_q  <= INIT_INC;
      pending_q <= 1'b0;
      carry_q   <= 1'b0;
      ce_q      <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      carry_q   <= carry_d;
      ce_q      <= ce_d;
    end
  end

  assign status_o.ce      = ce_q;
  assign status_o.pending = pending_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator: config decode, sync fan-out,
// lock tracking, and one NCO per channel.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int unsigned              NUM_CH      = 2,
  parameter int unsigned              ACC_W       = 32,
  parameter logic [NUM_CH*ACC_W-1:0]  INIT_INC    = {NUM_CH{{2'b01, {(ACC_W-2){1'b0}}}}},
  parameter int unsigned              LOCK_CYCLES = 16,
  localparam int unsigned             CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               refclk_i,
  input  logic               rst_ni,
  input  logic [NUM_CH-1:0]  ch_en_i,
  input  logic               sync_i,
  input  logic               cfg_we_i,
  input  logic [CH_W-1:0]    cfg_ch_i,
  input  logic [ACC_W-1:0]   cfg_inc_i,
  output logic [NUM_CH-1:0]  ce_out_o,
  output logic [NUM_CH-1:0]  pending_o,
  output logic               locked_o
);

  localparam int unsigned         LockCw  = lock_cw(LOCK_CYCLES);
  localparam logic [LockCw-1:0]   LockMax = LockCw'(LOCK_CYCLES);

  logic                cfg_valid;
  logic [NUM_CH-1:0]   ch_we;
  nco_status_t         status [NUM_CH];
  logic [LockCw-1:0]   lock_cnt_q, lock_cnt_d;

  // Writes to non-existent channels are dropped and must not disturb lock.
  assign cfg_valid = cfg_we_i && (32'(cfg_ch_i) < NUM_CH);

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    assign ch_we[g] = cfg_valid && (32'(cfg_ch_i) == 32'(g));

    clk_en_gen_nco #(
      .ACC_W    (ACC_W),
      .INIT_INC (INIT_INC[g*ACC_W +: ACC_W])
    ) u_nco (
      .clk_i    (refclk_i),
      .rst_ni   (rst_ni),
      .en_i     (ch_en_i[g]),
      .sync_i   (sync_i),
      .we_i     (ch_we[g]),
      .inc_i    (cfg_inc_i),
      .status_o (status[g])
    );

    assign ce_out_o[g]  = status[g].ce;
    assign pending_o[g] = status[g].pending;
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (cfg_valid) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q < LockMax) begin
      lock_cnt_d = lock_cnt_q + LockCw'(1);
    end
  end

  always_ff @(posedge refclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Built from registers only, so reset forces it low without waiting for an edge.
  assign locked_o = (lock_cnt_q == LockMax) && !(|pending_o);

endmodule

// File: tb/tb_clk_en_gen.sv
// Bench for clk_en_gen: constant table after reset, directed corner sequences,
// then random traffic against a cycle-level model of the rate/apply/lock rules.
module tb_clk_en_gen;

  localparam int unsigned NCH  = 3;
  localparam int unsigned AW   = 4;
  localparam int unsigned LOCK = 16;
  localparam int          MODV = 1 << AW;
  localparam logic [NCH*AW-1:0] INIT = {4'd2, 4'd8, 4'd4};

  logic           refclk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] ch_en;
  logic           sync;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [AW-1:0]  cfg_inc;
  logic [NCH-1:0] ce_out;
  logic [NCH-1:0] pending;
  logic           locked;

  clk_en_gen #(
    .NUM_CH      (NCH),
    .ACC_W       (AW),
    .INIT_INC    (INIT),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .refclk_i  (refclk),
    .rst_ni    (rst_n),
    .ch_en_i   (ch_en),
    .sync_i    (sync),
    .cfg_we_i  (cfg_we),
    .cfg_ch_i  (cfg_ch),
    .cfg_inc_i (cfg_inc),
    .ce_out_o  (ce_out),
    .pending_o (pending),
    .locked_o  (locked)
  );

  always #5 refclk = ~refclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase as an integer, strobe one cycle after the wrap that produced it.
  int m_acc [NCH];
  int m_act [NCH];
  int m_sh  [NCH];
  bit m_pend[NCH];
  bit m_wrap[NCH];
  bit m_ce  [NCH];
  int m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_acc[c]  = 0;
      m_act[c]  = int'(INIT[c*AW +: AW]);
      m_sh[c]   = m_act[c];
      m_pend[c] = 1'b0;
      m_wrap[c] = 1'b0;
      m_ce[c]   = 1'b0;
    end
    m_cnt = 0;
  endtask

  function automatic bit will_wrap(input int c);
    return ch_en[c] && !sync && (m_acc[c] + m_act[c] >= MODV);
  endfunction

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit w;
      w = will_wrap(c);
      if (sync) begin
        m_acc[c] = 0; m_ce[c] = 1'b0; m_wrap[c] = 1'b0;
      end else if (ch_en[c]) begin
        m_ce[c]   = m_wrap[c];
        m_wrap[c] = w;
        m_acc[c]  = (m_acc[c] + m_act[c]) % MODV;
      end else begin
        m_ce[c] = 1'b0; m_wrap[c] = 1'b0;
      end
      if (w || !ch_en[c] || sync) begin
        m_act[c] = m_sh[c]; m_pend[c] = 1'b0;
      end
      if (cfg_we && int'(cfg_ch) == c) begin
        m_sh[c] = int'(cfg_inc); m_pend[c] = 1'b1;
      end
    end
    if (cfg_we && int'(cfg_ch) < NCH) m_cnt = 0;
    else if (m_cnt < LOCK) m_cnt++;
  endtask

  function automatic logic [NCH-1:0] exp_ce();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_ce[c];
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_pend();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_pend[c];
    return v;
  endfunction

  function automatic logic exp_lock();
    return (m_cnt == LOCK) && (exp_pend() == '0);
  endfunction

  task automatic cyc();
    @(posedge refclk);
    model_step();
    #1;
    chk("model_ce", 32'(ce_out), 32'(exp_ce()));
    chk("model_pending", 32'(pending), 32'(exp_pend()));
    chk("model_locked", 32'(locked), 32'(exp_lock()));
  endtask

  task automatic write(input logic [1:0] ch, input logic [AW-1:0] inc);
    cfg_we = 1'b1; cfg_ch = ch; cfg_inc = inc;
    cyc();
    cfg_we = 1'b0;
  endtask

  typedef struct {
    logic [NCH-1:0] en;
    logic           we;
    logic [1:0]     ch;
    logic [AW-1:0]  inc;
    logic [NCH-1:0] exp_ce;
    logic           exp_lock;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int n;
    int cnt;
    // Rows are cycles 1..18 after reset release: ch0 every 4th, ch1 every 2nd, ch2 every 8th.
    tbl[0]  = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 1'b0};
    tbl[1]  = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 1'b0};
    tbl[2]  = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b010, 1'b0};
    tbl[3]  = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 1'b0};
    tbl[4]  = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b011, 1'b0};
    tbl[5]  = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 1'b0};
    tbl[6]  = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b010, 1'b0};
    tbl[7]  = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 1'b0};
    tbl[8]  = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b111, 1'b0};
    tbl[9]  = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 1'b0};
    tbl[10] = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b010, 1'b0};
    tbl[11] = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 1'b0};
    tbl[12] = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b011, 1'b0};
    tbl[13] = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 1'b0};
    tbl[14] = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b010, 1'b0};
    tbl[15] = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 1'b1};
    tbl[16] = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b111, 1'b1};
    tbl[17] = '{3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 1'b1};

    rst_n = 1'b0; ch_en = 3'b111; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_inc = '0;
    model_reset();
    repeat (3) @(posedge refclk);
    #1;
    chk("reset_ce", 32'(ce_out), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      ch_en = tbl[i].en; cfg_we = tbl[i].we; cfg_ch = tbl[i].ch; cfg_inc = tbl[i].inc;
      cyc();
      chk($sformatf("tbl%0d_ce", i), 32'(ce_out), 32'(tbl[i].exp_ce));
      chk($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].exp_lock));
    end
    cfg_we = 1'b0;

    // Retune ch0 to 15/16 mid-period: deferred until the next ch0 wrap.
    write(2'd0, 4'd15);
    chk("retune_pending", 32'(pending[0]), 32'd1);
    chk("retune_unlock", 32'(locked), 32'd0);
    n = 0;
    while (pending[0] && n < 20) begin cyc(); n++; end
    chk("retune_applied", 32'(pending[0]), 32'd0);
    repeat (4) cyc();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin cyc(); cnt += int'(ce_out[0]); end
    chk("rate_15_of_16", 32'(cnt), 32'd15);

    // Write landing on a wrap: old shadow applied, new one stays pending.
    write(2'd0, 4'd2);
    n = 0;
    while (!will_wrap(0) && n < 40) begin cyc(); n++; end
    chk("found_wrap", 32'(will_wrap(0)), 32'd1);
    write(2'd0, 4'd8);
    chk("wrap_write_pending", 32'(pending[0]), 32'd1);
    n = 0;
    while (pending[0] && n < 12) begin cyc(); n++; end
    chk("wrap_write_applied", 32'(pending[0]), 32'd0);

    // Disable ch1 for 5 cycles with a write landing during the gap.
    ch_en = 3'b101;
    cyc();
    chk("dis_ce1_0", 32'(ce_out[1]), 32'd0);
    write(2'd1, 4'd4);
    chk("dis_ce1_1", 32'(ce_out[1]), 32'd0);
    chk("dis_pending_set", 32'(pending[1]), 32'd1);
    cyc();
    chk("dis_pending_applied", 32'(pending[1]), 32'd0);
    for (int i = 0; i < 2; i++) begin cyc(); chk("dis_ce1", 32'(ce_out[1]), 32'd0); end
    ch_en = 3'b111;
    repeat (8) cyc();

    // Phase align ch0/ch1 (both inc 4) with sync.
    write(2'd0, 4'd4);
    n = 0;
    while (pending != '0 && n < 20) begin cyc(); n++; end
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    chk("sync_ce", 32'(ce_out), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk($sformatf("sync_k%0d", k), 32'(ce_out[1:0]), (k == 5) ? 32'd3 : 32'd0);
    end

    // Out-of-range channel write is ignored.
    n = 0;
    while (!locked && n < 40) begin cyc(); n++; end
    chk("relocked", 32'(locked), 32'd1);
    write(2'd3, 4'd1);
    chk("badch_locked", 32'(locked), 32'd1);
    chk("badch_pending", 32'(pending), 32'd0);
    repeat (6) cyc();

    // Async reset while a strobe is high.
    n = 0;
    while (exp_ce() == '0 && n < 20) begin cyc(); n++; end
    chk("strobe_seen", 32'(ce_out != '0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ce", 32'(ce_out), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_pending", 32'(pending), 32'd0);
    model_reset();
    @(posedge refclk);
    #1;
    rst_n = 1'b1;
    cyc();
    chk("release_no_strobe", 32'(ce_out), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NCH; c++) ch_en[c] = ($urandom_range(7) != 0);
      sync    = ($urandom_range(31) == 0);
      cfg_we  = ($urandom_range(5) == 0);
      cfg_ch  = 2'($urandom_range(3));
      cfg_inc = AW'($urandom);
      cyc();
    end
    ch_en = 3'b111; sync = 1'b0; cfg_we = 1'b0;
    repeat (20) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
